// File: rtl/command_assembler_pkg.sv
// Shared definitions for the terminal command path: ASCII constants,
// assembler state encoding, byte classification and case folding.
package command_assembler_pkg;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_TILDE = 8'h7E;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_DEL   = 8'h7F;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ESC   = 8'h1B;
  localparam logic [7:0] ASC_UC_A  = 8'h41;
  localparam logic [7:0] ASC_UC_Z  = 8'h5A;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_OVER    = 1'b1
  } asm_state_e;

  typedef enum logic [2:0] {
    CLS_IGNORE = 3'd0,
    CLS_PRINT  = 3'd1,
    CLS_BS     = 3'd2,
    CLS_ENTER  = 3'd3,
    CLS_ESC    = 3'd4
  } byte_class_e;

  // Map 'A'-'Z' to 'a'-'z'; every other byte passes through unchanged.
  function automatic logic [7:0] fold_lower(input logic [7:0] b);
    logic [7:0] r;
    if ((b >= ASC_UC_A) && (b <= ASC_UC_Z)) begin
      r = b + 8'h20;
    end else begin
      r = b;
    end
    return r;
  endfunction

  // Sort a received byte into the classes the line editor reacts to.
  function automatic byte_class_e classify_byte(input logic [7:0] b);
    byte_class_e c;
    if ((b >= ASC_SPACE) && (b <= ASC_TILDE)) begin
      c = CLS_PRINT;
    end else if ((b == ASC_BS) || (b == ASC_DEL)) begin
      c = CLS_BS;
    end else if ((b == ASC_CR) || (b == ASC_LF)) begin
      c = CLS_ENTER;
    end else if (b == ASC_ESC) begin
      c = CLS_ESC;
    end else begin
      c = CLS_IGNORE;
    end
    return c;
  endfunction

endpackage

// File: rtl/command_assembler_echo_buffer.sv
// One-deep valid/ready register holding the byte echoed to the terminal.
// A new byte offered while an un-accepted byte is pending is discarded.
module echo_buffer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       echo_ready,
  output logic       echo_valid,
  output logic [7:0] echo_data
);

  logic       valid_q;
  logic       valid_d;
  logic [7:0] data_q;
  logic [7:0] data_d;
  logic       accept_s;

  assign accept_s = valid_q & echo_ready;

  // Load when the slot is empty or being emptied this cycle; otherwise drop.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_valid && (!valid_q || accept_s)) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (accept_s) begin
      valid_d = 1'b0;
      data_d  = data_q;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Echo slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign echo_valid = valid_q;
  assign echo_data  = data_q;

endmodule

// File: rtl/command_assembler.sv
// Line editor between the UART receiver and the command decoder: collects
// printable characters, handles backspace/escape/enter and publishes a
// left-justified, space-padded command word, echoing keystrokes back.
module command_assembler
  import command_assembler_pkg::*;
#(
  parameter int CMD_LEN   = 5,
  parameter bit FOLD_CASE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [8*CMD_LEN-1:0] command,
  output logic                 cmd_valid,
  output logic                 cmd_error,
  output logic [7:0]           echo_data,
  output logic                 echo_valid,
  input  logic                 echo_ready,
  output logic                 overflow
);

  localparam int                  CW      = $clog2(CMD_LEN + 1);
  localparam logic [CW-1:0]       LEN_C   = CW'(CMD_LEN);
  localparam logic [CW-1:0]       ONE_C   = CW'(1);
  localparam logic [CW-1:0]       ZERO_C  = CW'(0);
  localparam logic [8*CMD_LEN-1:0] BLANK_C = {CMD_LEN{ASC_SPACE}};

  asm_state_e           state_q;
  asm_state_e           state_d;
  logic [8*CMD_LEN-1:0] buf_q;
  logic [8*CMD_LEN-1:0] buf_d;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic [8*CMD_LEN-1:0] command_q;
  logic [8*CMD_LEN-1:0] command_d;
  logic                 cmd_valid_q;
  logic                 cmd_valid_d;
  logic                 cmd_error_q;
  logic                 cmd_error_d;
  logic                 overflow_q;
  logic                 overflow_d;
  logic                 echo_load_s;
  logic [7:0]           echo_byte_s;
  byte_class_e          cls_s;
  logic [7:0]           char_s;

  assign cls_s  = classify_byte(rx_data);
  assign char_s = FOLD_CASE ? fold_lower(rx_data) : rx_data;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter OVER on a character past the line length, leave on Enter/Esc.
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        ST_COLLECT: begin
          if ((cls_s == CLS_PRINT) && (count_q == LEN_C)) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_OVER: begin
          if ((cls_s == CLS_ENTER) || (cls_s == CLS_ESC)) begin
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_OVER;
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and outputs: line buffer edits, commit, error pulse and echo request.
  always_comb begin
    buf_d       = buf_q;
    count_d     = count_q;
    command_d   = command_q;
    cmd_valid_d = 1'b0;
    cmd_error_d = 1'b0;
    overflow_d  = overflow_q;
    echo_load_s = 1'b0;
    echo_byte_s = 8'h00;
    if (rx_valid) begin
      case (state_q)
        ST_COLLECT: begin
          case (cls_s)
            CLS_PRINT: begin
              echo_load_s = 1'b1;
              echo_byte_s = rx_data;
              if (count_q < LEN_C) begin
                for (int i = 0; i < CMD_LEN; i++) begin
                  buf_d[8*(CMD_LEN-1-i) +: 8] =
                    (CW'(i) == count_q) ? char_s : buf_q[8*(CMD_LEN-1-i) +: 8];
                end
                count_d = count_q + ONE_C;
              end else begin
                overflow_d = 1'b1;
              end
            end
            CLS_BS: begin
              if (count_q != ZERO_C) begin
                for (int i = 0; i < CMD_LEN; i++) begin
                  buf_d[8*(CMD_LEN-1-i) +: 8] =
                    ((CW'(i) + ONE_C) == count_q) ? ASC_SPACE : buf_q[8*(CMD_LEN-1-i) +: 8];
                end
                count_d     = count_q - ONE_C;
                echo_load_s = 1'b1;
                echo_byte_s = ASC_BS;
              end else begin
                echo_load_s = 1'b0;
              end
            end
            CLS_ENTER: begin
              echo_load_s = 1'b1;
              echo_byte_s = ASC_CR;
              if (count_q != ZERO_C) begin
                command_d   = buf_q;
                cmd_valid_d = 1'b1;
                buf_d       = BLANK_C;
                count_d     = ZERO_C;
              end else begin
                cmd_valid_d = 1'b0;
              end
            end
            CLS_ESC: begin
              buf_d   = BLANK_C;
              count_d = ZERO_C;
            end
            default: echo_load_s = 1'b0;
          endcase
        end
        ST_OVER: begin
          case (cls_s)
            CLS_PRINT: begin
              echo_load_s = 1'b1;
              echo_byte_s = rx_data;
            end
            CLS_ENTER: begin
              cmd_error_d = 1'b1;
              buf_d       = BLANK_C;
              count_d     = ZERO_C;
              overflow_d  = 1'b0;
              echo_load_s = 1'b1;
              echo_byte_s = ASC_CR;
            end
            CLS_ESC: begin
              buf_d      = BLANK_C;
              count_d    = ZERO_C;
              overflow_d = 1'b0;
            end
            default: echo_load_s = 1'b0;
          endcase
        end
        default: echo_load_s = 1'b0;
      endcase
    end else begin
      echo_load_s = 1'b0;
    end
  end

  // Line buffer, held command and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q       <= BLANK_C;
      count_q     <= ZERO_C;
      command_q   <= BLANK_C;
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      count_q     <= count_d;
      command_q   <= command_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_error_q <= cmd_error_d;
      overflow_q  <= overflow_d;
    end
  end

  echo_buffer u_echo (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (echo_load_s),
    .load_data  (echo_byte_s),
    .echo_ready (echo_ready),
    .echo_valid (echo_valid),
    .echo_data  (echo_data)
  );

  assign command   = command_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_error = cmd_error_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_command_assembler.sv
// Directed table-driven bench for command_assembler: one folding and one
// non-folding instance share the same stimulus.
module tb_command_assembler;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        echo_ready;

  logic [39:0] command;
  logic        cmd_valid;
  logic        cmd_error;
  logic [7:0]  echo_data;
  logic        echo_valid;
  logic        overflow;

  logic [39:0] command_r;
  logic        cmd_valid_r;
  logic        cmd_error_r;
  logic [7:0]  echo_data_r;
  logic        echo_valid_r;
  logic        overflow_r;

  int n_cmp;
  int n_err;

  command_assembler #(.CMD_LEN(5), .FOLD_CASE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .command(command), .cmd_valid(cmd_valid), .cmd_error(cmd_error),
    .echo_data(echo_data), .echo_valid(echo_valid), .echo_ready(echo_ready),
    .overflow(overflow)
  );

  command_assembler #(.CMD_LEN(5), .FOLD_CASE(1'b0)) dut_raw (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .command(command_r), .cmd_valid(cmd_valid_r), .cmd_error(cmd_error_r),
    .echo_data(echo_data_r), .echo_valid(echo_valid_r), .echo_ready(echo_ready),
    .overflow(overflow_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rx;
    logic        vld;
    logic        rdy;
    logic [39:0] cmd;
    logic [39:0] cmd_raw;
    logic        cv;
    logic        ce;
    logic        ov;
    logic        ev;
    logic [7:0]  ed;
  } vec_t;

  vec_t vecs[$];

  localparam logic [39:0] BLANK = 40'h2020202020;

  task automatic add(input logic [7:0] rx, input logic vld, input logic rdy,
                     input logic [39:0] cmd, input logic [39:0] cmd_raw,
                     input logic cv, input logic ce, input logic ov,
                     input logic ev, input logic [7:0] ed);
    vec_t v;
    v.rx = rx; v.vld = vld; v.rdy = rdy; v.cmd = cmd; v.cmd_raw = cmd_raw;
    v.cv = cv; v.ce = ce; v.ov = ov; v.ev = ev; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [39:0] c;
    n_cmp = 0;
    n_err = 0;
    reset_n    = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    echo_ready = 1'b1;

    // "how" CR
    add(8'h68, 1'b1, 1'b1, BLANK, BLANK, 1'b0, 1'b0, 1'b0, 1'b1, 8'h68);
    add(8'h6F, 1'b1, 1'b1, BLANK, BLANK, 1'b0, 1'b0, 1'b0, 1'b1, 8'h6F);
    add(8'h77, 1'b1, 1'b1, BLANK, BLANK, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
    c = 40'h686F772020;
    add(8'h0D, 1'b1, 1'b1, c, c, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0D);
    add(8'h00, 1'b0, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // "HELLO" CR: folded vs raw
    add(8'h48, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h48);
    add(8'h45, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h45);
    add(8'h4C, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h4C);
    add(8'h4C, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h4C);
    add(8'h4F, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h4F);
    add(8'h0D, 1'b1, 1'b1, 40'h68656C6C6F, 40'h48454C4C4F, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0D);
    add(8'h00, 1'b0, 1'b1, 40'h68656C6C6F, 40'h48454C4C4F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // "sx" BS "ub" CR
    add(8'h73, 1'b1, 1'b1, 40'h68656C6C6F, 40'h48454C4C4F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h73);
    add(8'h78, 1'b1, 1'b1, 40'h68656C6C6F, 40'h48454C4C4F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h78);
    add(8'h08, 1'b1, 1'b1, 40'h68656C6C6F, 40'h48454C4C4F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
    add(8'h75, 1'b1, 1'b1, 40'h68656C6C6F, 40'h48454C4C4F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h75);
    add(8'h62, 1'b1, 1'b1, 40'h68656C6C6F, 40'h48454C4C4F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h62);
    c = 40'h7375622020;
    add(8'h0D, 1'b1, 1'b1, c, c, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0D);
    add(8'h00, 1'b0, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // "resets" BS 'z' CR: overlong line rejected
    add(8'h72, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h72);
    add(8'h65, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h65);
    add(8'h73, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h73);
    add(8'h65, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h65);
    add(8'h74, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h74);
    add(8'h73, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b1, 1'b1, 8'h73);
    add(8'h08, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    add(8'h7A, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7A);
    add(8'h0D, 1'b1, 1'b1, c, c, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0D);
    add(8'h00, 1'b0, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // "abcdef" ESC CR: escape out of OVER, then empty Enter
    add(8'h61, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h61);
    add(8'h62, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h62);
    add(8'h63, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h63);
    add(8'h64, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h64);
    add(8'h65, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h65);
    add(8'h66, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66);
    add(8'h1B, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(8'h0D, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0D);
    // ignored byte, BS and DEL on an empty line
    add(8'h01, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(8'h08, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(8'h7F, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // 'q' ESC CR: escape discards the line in COLLECT
    add(8'h71, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h71);
    add(8'h1B, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(8'h0D, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0D);
    // 'X' LF: line feed commits and echoes CR
    add(8'h58, 1'b1, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 8'h58);
    add(8'h0A, 1'b1, 1'b1, 40'h7820202020, 40'h5820202020, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0D);
    c = 40'h7820202020;
    add(8'h00, 1'b0, 1'b1, c, 40'h5820202020, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // echo back-pressure: "12" with ready low, second echo dropped
    add(8'h31, 1'b1, 1'b0, c, 40'h5820202020, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31);
    add(8'h32, 1'b1, 1'b0, c, 40'h5820202020, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31);
    add(8'h00, 1'b0, 1'b0, c, 40'h5820202020, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31);
    add(8'h00, 1'b0, 1'b1, c, 40'h5820202020, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    c = 40'h3132202020;
    add(8'h0D, 1'b1, 1'b1, c, c, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0D);
    add(8'h00, 1'b0, 1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset command", command, BLANK);
    chk("reset command raw", command_r, BLANK);
    chk("reset cmd_valid", {39'd0, cmd_valid}, 40'd0);
    chk("reset cmd_error", {39'd0, cmd_error}, 40'd0);
    chk("reset overflow", {39'd0, overflow}, 40'd0);
    chk("reset echo_valid", {39'd0, echo_valid}, 40'd0);
    chk("reset echo_data", {32'd0, echo_data}, 40'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // table vectors: drive on the falling edge, check just after the rising edge
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rx_data    = vecs[i].rx;
      rx_valid   = vecs[i].vld;
      echo_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d command", i), command, vecs[i].cmd);
      chk($sformatf("v%0d command_raw", i), command_r, vecs[i].cmd_raw);
      chk($sformatf("v%0d cmd_valid", i), {39'd0, cmd_valid}, {39'd0, vecs[i].cv});
      chk($sformatf("v%0d cmd_error", i), {39'd0, cmd_error}, {39'd0, vecs[i].ce});
      chk($sformatf("v%0d overflow", i), {39'd0, overflow}, {39'd0, vecs[i].ov});
      chk($sformatf("v%0d echo_valid", i), {39'd0, echo_valid}, {39'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d echo_data", i), {32'd0, echo_data}, {32'd0, vecs[i].ed});
      end
    end

    // mid-line asynchronous reset: "ab", reset, then Enter on an empty line
    @(negedge clk);
    rx_data = 8'h61; rx_valid = 1'b1; echo_ready = 1'b1;
    @(negedge clk);
    rx_data = 8'h62;
    @(negedge clk);
    rx_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset command", command, BLANK);
    chk("async reset echo_valid", {39'd0, echo_valid}, 40'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rx_data = 8'h0D; rx_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset cmd_valid", {39'd0, cmd_valid}, 40'd0);
    chk("post-reset command", command, BLANK);
    chk("post-reset echo_valid", {39'd0, echo_valid}, 40'd1);
    chk("post-reset echo_data", {32'd0, echo_data}, 40'h0D);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset idle cmd_valid", {39'd0, cmd_valid}, 40'd0);
    chk("post-reset idle echo_valid", {39'd0, echo_valid}, 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/command_assembler.md
Name: command_assembler

Overview:
- Upstream neighbour of the command decoder: converts the UART receive byte stream from the terminal into the fixed-width ASCII command word the decoder consumes.
- Collects printable characters into a CMD_LEN-character line buffer and handles backspace, escape and line termination.
- On Enter, publishes a left-justified, space-padded command word and holds it until the next commit.
- Produces a one-deep echo stream back to the UART transmitter.

Parameters:
- CMD_LEN, 5: characters per command. The command word is 8*CMD_LEN bits; the first character is in the MSB byte.
- FOLD_CASE, 1: when 1, ASCII 'A'-'Z' (0x41-0x5A) are stored as lowercase (+0x20).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received ASCII byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- command  out  8*CMD_LEN  last committed command, held
- cmd_valid  out  1  one-cycle pulse, command just updated
- cmd_error  out  1  one-cycle pulse, overlong line rejected
- echo_data  out  8  byte to echo to the terminal
- echo_valid  out  1  echo byte pending
- echo_ready  in  1  transmitter accepts echo_data
- overflow  out  1  current line has exceeded CMD_LEN

Behaviour:
- Reset values (async on reset_n low): buffer all 0x20, count=0, command all 0x20, cmd_valid=0, cmd_error=0, echo_valid=0, echo_data=0x00, overflow=0, state=COLLECT.
- Byte classes, evaluated on the rx_valid cycle:
  - PRINT: 0x20-0x7E.
  - BS: 0x08 or 0x7F.
  - ENTER: 0x0D or 0x0A.
  - ESC: 0x1B.
  - All other bytes are ignored, with no echo.
- Bytes only act when rx_valid=1; all effects are visible the following cycle (latency 1).
- States: COLLECT, OVER.
- COLLECT:
  - PRINT with count<CMD_LEN: buffer[count] <= (case-folded) byte; count++; echo the byte.
  - PRINT with count==CMD_LEN: byte dropped; overflow<=1; go to OVER; echo the byte.
  - BS with count>0: count--; buffer[count-1] <= 0x20; echo 0x08.
  - BS with count==0: no action, no echo.
  - ENTER with count>0: command <= buffer (positions >= count are already 0x20); cmd_valid pulses 1 cycle; buffer cleared to 0x20; count=0; echo 0x0D.
  - ENTER with count==0: no commit, no pulse; echo 0x0D.
  - ESC: buffer cleared; count=0; no echo.
- OVER:
  - PRINT: dropped; echoed.
  - BS: ignored.
  - ENTER: command unchanged; cmd_error pulses 1 cycle; buffer cleared; count=0; overflow<=0; go to COLLECT; echo 0x0D.
  - ESC: same as ENTER except no cmd_error pulse and no echo.
- command holds its value between commits; the decoder samples it every clock.
- Echo handshake:
  - echo_valid rises the cycle after the triggering byte.
  - echo_valid falls the cycle after echo_valid&&echo_ready.
  - echo_data is stable while echo_valid=1.
  - If a new echo is generated while one is still pending and not accepted in that same cycle, the new echo is dropped. Buffer and state updates still occur.
  - If echo_ready completes the handshake in the same cycle a new echo is generated, the new echo loads and echo_valid stays 1.
- cmd_valid and cmd_error are never asserted together and never for more than one cycle.
- Reset asserted mid-line discards the partial line and the held command.

Decomposition:
- Shared package, also used by the decoder:
  - ASCII constants ASC_SPACE, ASC_BS, ASC_DEL, ASC_CR, ASC_LF, ASC_ESC.
  - State enumeration for COLLECT/OVER.
  - Function fold_lower(byte).
- One sub-module, echo_buffer: the one-deep valid/ready echo register with a drop-on-busy policy.

Test Plan:
- Send "how",0x0D with echo_ready=1 -> command=0x686F772020, cmd_valid pulses once 1 cycle after 0x0D, echoes 68,6F,77,0D.
- Send "HELLO",0x0D with FOLD_CASE=1 -> command=0x68656C6C6F; with FOLD_CASE=0 -> command=0x48454C4C4F.
- Send "sx",0x08,"ub",0x0D -> after 0x08 count=1 and buffer[1]=0x20; final command=0x7375622020 ("sub  "); echo includes 0x08.
- Send "resets",0x0D -> overflow=1 after 's', cmd_error pulses, cmd_valid stays 0, command keeps its prior value, overflow=0 after Enter.
- Hold echo_ready=0 and send "12" -> echo_valid=1 with echo_data=0x31, '2' echo dropped; raise echo_ready -> echo_valid=0 next cycle; "12",0x0D still commits 0x3132202020.
- Send "ab", pull reset_n low asynchronously, release, send 0x0D -> command=0x2020202020 and no cmd_valid (empty line).
